// File: rtl/image_stream_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_scheduler_pkg
//  Brief    : Shared types and default image dimensions for the image
//             stream scheduler and its prefetch buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package image_stream_scheduler_pkg;

    // Default image geometry and pixel format (matches the image parameter header)
    localparam int IMG_W_DEF   = 64;
    localparam int IMG_H_DEF   = 48;
    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 10;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_WAIT_PROC = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage : image_stream_scheduler_pkg
`default_nettype wire

// File: rtl/pixel_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_prefetch_fifo
//  Brief    : Two-entry synchronous FIFO holding prefetched pixels. Head is
//             presented combinationally; simultaneous push and pop are both
//             honoured.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_prefetch_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // A pop needs data; a push needs room unless a pop frees a slot this cycle
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == 2'd0);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Register state; reset empties the buffer and clears its contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The scheduler's read throttling must keep a push from landing on a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == 2'd2) && !pop));

    a_occupancy: assert property (@(posedge clk) disable iff (!reset)
        count_q <= 2'd2);

endmodule : pixel_prefetch_fifo
`default_nettype wire

// File: rtl/image_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_scheduler
//  Brief    : Sequences load -> process -> stream. Streams the processed frame
//             from a synchronous pixel memory (descending addresses) to the
//             VGA controller, one pixel per divider tick, through a 2-entry
//             prefetch buffer. Flags end of frame and buffer underruns.
//  Revision : 1.0 - initial release
// ============================================================================
module image_stream_scheduler
    import image_stream_scheduler_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int ADDR_W  = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_done,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int                NUM_PIX   = IMG_W * IMG_H;
    localparam int                CNT_W     = ADDR_W + 1;
    localparam int                DIV_W     = $clog2(CLK_DIV);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(NUM_PIX - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               addr_left_q, addr_left_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [DATA_W-1:0]  pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic               pix_last_q, pix_last_d;
    logic               frame_done_q, frame_done_d;
    logic               underrun_q, underrun_d;

    logic               in_stream;
    logic               tick;
    logic               fifo_push;
    logic               fifo_pop;
    logic [DATA_W-1:0]  fifo_head;
    logic [1:0]         fifo_count;
    logic               fifo_empty;

    assign in_stream = (state_q == ST_STREAM);
    assign tick      = in_stream && (div_q == DIV_MAX);

    // Issue a read only when the buffer plus the outstanding read leaves room
    assign rd_en = in_stream && addr_left_q &&
                   ((fifo_count + {1'b0, inflight_q}) < 2'd2);

    // Data returns one cycle after the strobe; ignore it once streaming stops
    assign fifo_push = inflight_q && in_stream;
    assign fifo_pop  = tick && !fifo_empty;

    assign proc_start = (state_q == ST_WAIT_LOAD) && load_done;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign rd_addr    = rd_addr_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    pixel_prefetch_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (rd_data),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Next-state: FSM, divider, read address generator and pixel emission
    always_comb begin
        state_d      = state_q;
        div_d        = '0;
        rd_addr_d    = rd_addr_q;
        addr_left_d  = addr_left_q;
        inflight_d   = rd_en;
        pix_cnt_d    = pix_cnt_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        pix_last_d   = 1'b0;
        frame_done_d = frame_done_q | (pix_valid_q & pix_last_q);
        underrun_d   = underrun_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                if (load_done) begin
                    state_d = ST_WAIT_PROC;
                end
            end
            ST_WAIT_PROC: begin
                if (proc_done) begin
                    state_d     = ST_STREAM;
                    rd_addr_d   = LAST_ADDR;
                    addr_left_d = 1'b1;
                    pix_cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (rd_en) begin
                    if (rd_addr_q == '0) begin
                        addr_left_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q - 1'b1;
                    end
                end
                if (fifo_pop) begin
                    pix_data_d  = fifo_head;
                    pix_valid_d = 1'b1;
                    pix_cnt_d   = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_last_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else if (tick) begin
                    underrun_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d      = ST_WAIT_LOAD;
                    frame_done_d = 1'b0;
                    underrun_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial frame and any read in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            rd_addr_q    <= '0;
            addr_left_q  <= 1'b0;
            inflight_q   <= 1'b0;
            pix_cnt_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            rd_addr_q    <= rd_addr_d;
            addr_left_q  <= addr_left_d;
            inflight_q   <= inflight_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule : image_stream_scheduler
`default_nettype wire

// File: doc/image_stream_scheduler.md
Name: image_stream_scheduler

Overview:
- Sequences the image pipeline: waits for the image load to finish, starts the processing stage, then streams the processed frame to the VGA controller one pixel per pixel tick.
- Reads the processed image from a synchronous pixel memory by address and prefetches into a 2-entry buffer.
- Contains its own pixel-rate clock-enable divider, so there is no derived clock.
- Raises the end-of-frame indicator that drives the LED.

Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 48, image height in pixels
- DATA_W, 8, pixel width in bits
- CLK_DIV, 10, system clocks per pixel tick (50 MHz -> 5 MHz); must be >= 3
- ADDR_W, $clog2(IMG_W*IMG_H), derived; memory address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame sequence
- load_done  in  1  level; image load into the input buffer is complete
- proc_start  out  1  one-cycle pulse that launches the processing stage
- proc_done  in  1  one-cycle pulse; processing stage has finished
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  ADDR_W  pixel memory address
- rd_data  in  DATA_W  memory data, valid exactly 1 cycle after rd_en
- pix_data  out  DATA_W  pixel to the VGA controller
- pix_valid  out  1  one-cycle strobe; pix_data is new
- busy  out  1  high in any state other than IDLE and DONE
- frame_done  out  1  level; whole frame has been emitted (LED)
- underrun  out  1  sticky; a pixel tick found the buffer empty

Behaviour:
- Reset values (while reset=0): all outputs 0, state IDLE, buffer empty, divider 0, pixel counter 0.
- N = IMG_W*IMG_H. Pixels are emitted in descending address order: N-1 first, 0 last.
- FSM transitions:
  - IDLE -> WAIT_LOAD on start.
  - WAIT_LOAD -> WAIT_PROC on the first cycle with load_done=1; proc_start pulses in that same transition cycle.
  - WAIT_PROC -> STREAM on proc_done.
  - STREAM -> DONE in the cycle the Nth pixel is emitted.
  - DONE -> WAIT_LOAD on start; this clears frame_done and underrun in the same cycle.
- start is ignored in WAIT_LOAD, WAIT_PROC and STREAM. proc_done is ignored outside WAIT_PROC. load_done is only sampled in WAIT_LOAD.
- Prefetch (STREAM only):
  - On STREAM entry, the read address is set to N-1.
  - rd_en is asserted in any cycle where (occupancy + reads in flight) < 2 and addresses remain.
  - rd_addr decrements after each issued read. No reads are issued once address 0 has been issued.
  - Returned data is written into the buffer the cycle after rd_en. Buffer depth is 2, so it never overflows.
- Divider:
  - Cleared to 0 on STREAM entry; counts 0..CLK_DIV-1 while in STREAM and holds at 0 elsewhere.
  - Tick fires in the cycle divider == CLK_DIV-1, so the first tick is CLK_DIV cycles after entry.
- Emission:
  - On a tick with the buffer non-empty: pop the head to pix_data, pulse pix_valid, increment the pixel count.
  - On a tick with the buffer empty: set underrun, no pix_valid. The pixel is not skipped; it is emitted on a later tick.
  - A pop and a push in the same cycle are both honoured; occupancy is unchanged.
  - pix_data holds its last value between strobes.
- frame_done goes to 1 the cycle after the Nth pix_valid. It holds until the next start from DONE, or until reset.
- Reset mid-frame: everything returns to reset values immediately. No partial state survives. A data return from a read issued before reset is discarded.

Decomposition:
- Shared package holds:
  - state enum: IDLE, WAIT_LOAD, WAIT_PROC, STREAM, DONE
  - default image dimensions and DATA_W (same values as the existing image parameter header)
- One sub-module: pixel_prefetch_fifo, a 2-entry synchronous FIFO with push, pop, count and empty, async active-low reset.
- The divider and FSM stay inline.

Test Plan (IMG_W=4, IMG_H=2, CLK_DIV=4, memory holds data = 8'h10+addr):
- Full sequence: start, load_done=1 two cycles later, proc_done 5 cycles later -> proc_start single pulse; pix_valid every 4 cycles with data 17,16,...,10 (hex); frame_done=1 one cycle after 8th strobe; busy=0 and underrun=0 at the end.
- Ordering: start while in STREAM -> ignored, 8 pixels unchanged. proc_done while in WAIT_LOAD -> ignored, FSM stays in WAIT_LOAD and no proc_start.
- Slow memory model (rd_data delayed, first pixel missing on first tick) -> underrun=1, no pix_valid on that tick; pixel 17 appears on the next tick; 8 pixels in total, none skipped.
- Reset asserted after 3rd pix_valid -> all outputs 0 immediately. A new start and full sequence then emits 17..10 from the beginning.
- Restart from DONE: second start -> frame_done and underrun clear in that cycle; sequence repeats identically.
- rd_addr never outside 0..7; rd_en asserted exactly 8 times per frame; buffer occupancy never exceeds 2 (assertion).
